// File: rtl/nes_cpu_bus_pkg.sv
// Shared definitions for the CPU bus responder.
// Holds the address-region type, the responder FSM state encodings, the
// region boundary constants of the 16-bit CPU map and the region decoder.
package nes_cpu_bus_pkg;

  typedef enum logic [2:0] {
    RGN_RAM,
    RGN_PPU,
    RGN_IO,
    RGN_UNMAPPED,
    RGN_PRG
  } region_e;

  // Plain constants keep the state register a bare logic vector.
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_INT  = 3'd1;
  localparam logic [2:0] S_EXT  = 3'd2;
  localparam logic [2:0] S_DONE = 3'd3;
  localparam logic [2:0] S_HOLD = 3'd4;

  localparam logic [15:0] PPU_BASE      = 16'h2000;
  localparam logic [15:0] IO_BASE       = 16'h4000;
  localparam logic [15:0] UNMAPPED_BASE = 16'h4020;
  localparam logic [15:0] PRG_BASE      = 16'h8000;

  function automatic region_e decode_region(input logic [15:0] addr);
    region_e rgn;
    if (addr < PPU_BASE)           rgn = RGN_RAM;
    else if (addr < IO_BASE)       rgn = RGN_PPU;
    else if (addr < UNMAPPED_BASE) rgn = RGN_IO;
    else if (addr < PRG_BASE)      rgn = RGN_UNMAPPED;
    else                           rgn = RGN_PRG;
    return rgn;
  endfunction

endpackage

// File: rtl/cpu_bus_responder_if.sv
// Bundle of every signal between the CPU bus responder and its neighbours.
//   CPU side      : memory_access, rw_n, addr_bus, mem_data_out -> mem_data_in,
//                   mem_ready, bus_timeout
//   PPU port      : ppu_cs, ppu_rw_n, ppu_reg, ppu_wdata / ppu_rdata, ppu_ack
//   APU/IO port   : io_cs, io_rw_n, io_addr, io_wdata / io_rdata, io_ack
//   PRG ROM port  : prg_addr / prg_data (1-cycle synchronous read)
// slave  : the responder's view.
// master : the surrounding system's view (CPU plus PPU, IO and cartridge).
interface cpu_bus_responder_if #(
  parameter int unsigned PRG_AW = 15
) ();

  logic              memory_access;
  logic              rw_n;
  logic [15:0]       addr_bus;
  logic [7:0]        mem_data_out;
  logic [7:0]        mem_data_in;
  logic              mem_ready;
  logic              bus_timeout;

  logic              ppu_cs;
  logic              ppu_rw_n;
  logic [2:0]        ppu_reg;
  logic [7:0]        ppu_wdata;
  logic [7:0]        ppu_rdata;
  logic              ppu_ack;

  logic              io_cs;
  logic              io_rw_n;
  logic [4:0]        io_addr;
  logic [7:0]        io_wdata;
  logic [7:0]        io_rdata;
  logic              io_ack;

  logic [PRG_AW-1:0] prg_addr;
  logic [7:0]        prg_data;

  modport slave (
    input  memory_access, rw_n, addr_bus, mem_data_out,
    output mem_data_in, mem_ready, bus_timeout,
    output ppu_cs, ppu_rw_n, ppu_reg, ppu_wdata,
    input  ppu_rdata, ppu_ack,
    output io_cs, io_rw_n, io_addr, io_wdata,
    input  io_rdata, io_ack,
    output prg_addr,
    input  prg_data
  );

  modport master (
    output memory_access, rw_n, addr_bus, mem_data_out,
    input  mem_data_in, mem_ready, bus_timeout,
    input  ppu_cs, ppu_rw_n, ppu_reg, ppu_wdata,
    output ppu_rdata, ppu_ack,
    input  io_cs, io_rw_n, io_addr, io_wdata,
    output io_rdata, io_ack,
    input  prg_addr,
    output prg_data
  );

endinterface

// File: rtl/cpu_work_ram.sv
// 2048 x 8 synchronous single-port work RAM. Read data is registered; a
// read during a write returns the old contents. Contents have no reset.
//   i_clk   : clock
//   i_we    : write enable
//   i_addr  : word address
//   i_wdata : write data
//   o_rdata : registered read data
module cpu_work_ram (
  input  logic        i_clk,
  input  logic        i_we,
  input  logic [10:0] i_addr,
  input  logic [7:0]  i_wdata,
  output logic [7:0]  o_rdata
);

  logic [7:0] r_mem [2048];
  logic [7:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
    r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/cpu_bus_responder.sv
// Target side of the CPU memory-access interface. Decodes the NES CPU map,
// serves mirrored work RAM and PRG ROM internally, forwards PPU and APU/IO
// accesses over ack handshakes with a bounded wait, and returns every access
// with a one-cycle mem_ready pulse.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : cpu_bus_responder_if slave view (CPU, PPU, IO, PRG ports)
module cpu_bus_responder #(
  parameter int unsigned PRG_AW      = 15,
  parameter int unsigned EXT_TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  cpu_bus_responder_if.slave   bus
);

  import nes_cpu_bus_pkg::*;

  localparam int unsigned CntW = (EXT_TIMEOUT > 1) ? $clog2(EXT_TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(EXT_TIMEOUT - 1);

  logic [2:0]      r_state;
  region_e         r_region;
  logic [15:0]     r_addr;
  logic            r_rw_n;
  logic [7:0]      r_wdata;
  logic [7:0]      r_rdata;
  logic [CntW-1:0] r_cnt;
  logic            r_timed_out;
  logic [7:0]      r_mem_data_in;
  logic            r_mem_ready;
  logic            r_bus_timeout;

  region_e         w_region;
  logic            w_is_ext;
  logic            w_ack;
  logic [7:0]      w_ext_rdata;
  logic            w_ram_we;
  logic [7:0]      w_ram_rdata;
  logic            w_req_changed;

  assign w_region    = decode_region(bus.addr_bus);
  assign w_is_ext    = (w_region == RGN_PPU) || (w_region == RGN_IO);
  // Acks are only looked at in S_EXT, so a late ack is ignored.
  assign w_ack       = (r_region == RGN_PPU) ? bus.ppu_ack : bus.io_ack;
  assign w_ext_rdata = (r_region == RGN_PPU) ? bus.ppu_rdata : bus.io_rdata;
  assign w_ram_we    = (r_state == S_INT) && (r_region == RGN_RAM) && !r_rw_n;
  assign w_req_changed = !bus.memory_access || (bus.addr_bus != r_addr) ||
                         (bus.rw_n != r_rw_n);

  cpu_work_ram u_ram (
    .i_clk   (clk),
    .i_we    (w_ram_we),
    .i_addr  (r_addr[10:0]),
    .i_wdata (r_wdata),
    .o_rdata (w_ram_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_region      <= RGN_RAM;
      r_addr        <= '0;
      r_rw_n        <= 1'b1;
      r_wdata       <= '0;
      r_rdata       <= '0;
      r_cnt         <= '0;
      r_timed_out   <= 1'b0;
      r_mem_data_in <= '0;
      r_mem_ready   <= 1'b0;
      r_bus_timeout <= 1'b0;
    end else begin
      r_mem_ready   <= 1'b0;
      r_bus_timeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.memory_access) begin
            r_addr      <= bus.addr_bus;
            r_rw_n      <= bus.rw_n;
            r_wdata     <= bus.mem_data_out;
            r_region    <= w_region;
            r_cnt       <= '0;
            r_timed_out <= 1'b0;
            r_state     <= w_is_ext ? S_EXT : S_INT;
          end
        end
        S_INT: r_state <= S_DONE;
        S_EXT: begin
          // Ack beats a timeout falling on the same edge.
          if (w_ack) begin
            r_rdata <= w_ext_rdata;
            r_state <= S_DONE;
          end else if (r_cnt == CntLast) begin
            r_timed_out <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          r_mem_ready   <= 1'b1;
          r_bus_timeout <= r_timed_out;
          // Unmapped and timed-out reads leave the open-bus value in place.
          if (r_rw_n && !r_timed_out) begin
            case (r_region)
              RGN_RAM:         r_mem_data_in <= w_ram_rdata;
              RGN_PRG:         r_mem_data_in <= bus.prg_data;
              RGN_PPU, RGN_IO: r_mem_data_in <= r_rdata;
              default:         r_mem_data_in <= r_mem_data_in;
            endcase
          end
          r_state <= S_HOLD;
        end
        S_HOLD: if (w_req_changed) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.mem_data_in = r_mem_data_in;
  assign bus.mem_ready   = r_mem_ready;
  assign bus.bus_timeout = r_bus_timeout;

  assign bus.ppu_cs    = (r_state == S_EXT) && (r_region == RGN_PPU);
  assign bus.ppu_rw_n  = r_rw_n;
  assign bus.ppu_reg   = r_addr[2:0];
  assign bus.ppu_wdata = r_wdata;

  assign bus.io_cs     = (r_state == S_EXT) && (r_region == RGN_IO);
  assign bus.io_rw_n   = r_rw_n;
  assign bus.io_addr   = r_addr[4:0];
  assign bus.io_wdata  = r_wdata;

  assign bus.prg_addr  = r_addr[PRG_AW-1:0];

endmodule

// File: doc/cpu_bus_responder.md
# cpu_bus_responder

Target side of the CPU memory-access interface driven by the execute stage (`addr_bus`, `rw_n`, `memory_access`, `mem_data_out` → `mem_data_in`). It decodes the 16-bit NES CPU address map and services each access:

- 2 KB work RAM, mirrored, held internally.
- PPU register window, forwarded over a handshake port.
- APU/IO window, forwarded over a handshake port.
- PRG ROM, read through a synchronous port.

Every access returns read data with a one-cycle `mem_ready` pulse. It sits between the CPU pipeline and the PPU, APU/IO and cartridge blocks.

## Interface
Parameters:
- `PRG_AW`, 15 — PRG address width; 15 gives 32 KB, 14 gives 16 KB mirrored at 0xC000.
- `EXT_TIMEOUT`, 15 — maximum cycles to wait for `ppu_ack`/`io_ack` before forced completion.

Ports:
- `clk`  in  1  — single system clock, rising edge.
- `rst_n`  in  1  — asynchronous, active-low reset.
- `memory_access`  in  1  — access request, level.
- `rw_n`  in  1  — 1 = read, 0 = write.
- `addr_bus`  in  16  — CPU address.
- `mem_data_out`  in  8  — write data from CPU.
- `mem_data_in`  out  8  — read data to CPU (registered).
- `mem_ready`  out  1  — one-cycle completion pulse.
- `bus_timeout`  out  1  — one-cycle pulse on a forced external completion.
- `ppu_cs`, `ppu_rw_n`  out  1 each; `ppu_reg`  out  3; `ppu_wdata`  out  8; `ppu_rdata`  in  8; `ppu_ack`  in  1.
- `io_cs`, `io_rw_n`  out  1 each; `io_addr`  out  5; `io_wdata`  out  8; `io_rdata`  in  8; `io_ack`  in  1.
- `prg_addr`  out  PRG_AW; `prg_data`  in  8 — ROM has 1-cycle synchronous read.

## Operation
Address decode:
- 0x0000–0x1FFF → RAM, index `addr[10:0]`.
- 0x2000–0x3FFF → PPU, `ppu_reg = addr[2:0]`.
- 0x4000–0x401F → IO, `io_addr = addr[4:0]`.
- 0x4020–0x7FFF → UNMAPPED.
- 0x8000–0xFFFF → PRG, `prg_addr = addr[PRG_AW-1:0]`.

State machine:
- **IDLE**: when `memory_access`=1, latch `addr_bus`, `rw_n` and `mem_data_out`, decode the region, then go to INT (RAM/PRG/UNMAPPED) or EXT (PPU/IO).
- **INT**: one cycle. RAM write commits at the end of INT. RAM/PRG read data is registered. Go to DONE.
- **EXT**: assert the region's `*_cs` along with latched rw/addr/wdata. Stay until ack is sampled high or `EXT_TIMEOUT` cycles have elapsed. Then go to DONE.
- **DONE**: drive `mem_ready`=1 and update `mem_data_in` for a read. Go to HOLD.
- **HOLD**: return to IDLE when `memory_access`=0, or when `addr_bus`/`rw_n` differ from the latched values. A request held unchanged is never serviced twice. An address change is serviced starting in the following IDLE cycle.

Data rules:
- Writes leave `mem_data_in` unchanged.
- Writes to PRG or UNMAPPED are discarded but still complete.
- Open bus: UNMAPPED reads and timed-out reads return the current `mem_data_in` value.
- A timeout raises `bus_timeout` in the same cycle as `mem_ready`. Write data at timeout is dropped.
- `*_cs` is never asserted for RAM/PRG/UNMAPPED. At most one `*_cs` is high at a time.

## Timing
Acceptance edge is T (IDLE with `memory_access`=1).
- **RAM/PRG/UNMAPPED**: `mem_ready` and `mem_data_in` are registered at edge T+2. Fixed latency 2.
- **EXT**:
  - `*_cs` is high from edge T.
  - Ack sampled high at edge T+n (n≥1): `*_rdata` is captured, `*_cs` drops, and `mem_ready` pulses after edge T+n+1.
  - No ack: forced completion is registered at edge T+`EXT_TIMEOUT`+1.
- **Back-to-back**: minimum spacing from one `mem_ready` to the next is 4 cycles (HOLD→IDLE→accept→INT→DONE).
- **Reset values**: `mem_data_in`=0x00, `mem_ready`=0, `bus_timeout`=0, all `*_cs`=0, `*_rw_n`=1, addr/wdata outputs 0, state IDLE.
- **Reset mid-access**: the access is aborted immediately (asynchronous). A RAM write not yet committed is lost. RAM contents are not reset.
- **Ack and timeout on the same edge**: ack wins; no `bus_timeout`.
- **Late ack** after the `*_cs` deassertion is ignored.

## Structure
- Package `nes_cpu_bus_pkg` holds:
  - region enum `{RGN_RAM, RGN_PPU, RGN_IO, RGN_UNMAPPED, RGN_PRG}`;
  - state enum `{S_IDLE, S_INT, S_EXT, S_DONE, S_HOLD}`;
  - region base/limit constants (0x2000, 0x4000, 0x4020, 0x8000);
  - a `decode_region` function.
- Sub-module `cpu_work_ram`: 2048×8 synchronous single-port RAM (write-first not required), instantiated once.
- Remaining logic is the FSM plus the latch registers, in a single module.

## Test plan
- **RAM mirror**: write 0x5A to 0x0123, then read 0x0923 and 0x1923 → each `mem_data_in`=0x5A with `mem_ready` at T+2.
- **PPU handshake**: read 0x2002 with `ppu_ack` after 3 cycles and `ppu_rdata`=0x80 → `ppu_reg`=2, `ppu_cs` high for 3 cycles, `mem_data_in`=0x80. Read 0x3FFA → `ppu_reg`=2.
- **IO timeout**: write 0x4016 with no ack → `io_cs` for `EXT_TIMEOUT` cycles, then `mem_ready`+`bus_timeout` together, `mem_data_in` unchanged.
- **PRG mirror**: with `PRG_AW`=14, read 0xC010 → `prg_addr`=0x0010. Write 0x9000 → completes, no side effect.
- **Hold / no double service**:
  - `memory_access` held high at 0x0010 for 10 cycles → exactly one `mem_ready`.
  - Address changed to 0x0011 while still high → a second access with one `mem_ready`.
- **Open bus and reset**:
  - Read 0x0123 (0x5A), then read 0x5000 → `mem_data_in` stays 0x5A.
  - Assert `rst_n`=0 during an EXT wait → `ppu_cs`/`io_cs` low and `mem_data_in`=0x00 immediately.
